// File: rtl/adder_pipe.sv
// adder_pipe: valid/ready pipelined adder, one carry-chained slice per stage; ADDER_PIPE_SUB_EN adds a sub input
module adder_pipe #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = WIDTH / STAGES;
  logic [STAGES-1:0] vld, cy, pv, pc;
  logic [STAGES:0] rdy;
  logic [WIDTH-1:0] sum_r [STAGES];
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] pa [STAGES];
  logic [WIDTH-1:0] pb [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [WIDTH-1:0] b_in;
`ifdef ADDER_PIPE_SUB_EN
  assign b_in = sub ? ~b : b;
`else
  assign b_in = b;
`endif
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !vld[k] || rdy[k+1];
  end
  assign in_ready = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign sum = sum_r[STAGES-1];
  assign carry_out = cy[STAGES-1];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] ps;
    logic ci;
    logic [CW:0] s;
    if (k == 0) begin : g_head
      assign pa[k] = a;
      assign pb[k] = b_in;
      assign ps = '0;
      assign ci = carry_in;
      assign pv[k] = in_valid;
    end else begin : g_body
      assign pa[k] = a_r[k-1];
      assign pb[k] = b_r[k-1];
      assign ps = sum_r[k-1];
      assign ci = cy[k-1];
      assign pv[k] = vld[k-1];
    end
    assign s = {1'b0, pa[k][k*CW +: CW]} + {1'b0, pb[k][k*CW +: CW]} + {{CW{1'b0}}, ci};
    assign pc[k] = s[CW];
    assign ns[k] = ps | (WIDTH'(s[CW-1:0]) << (k * CW));
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld <= '0;
      cy <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_r[k] <= '0;
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= pv[k];
          cy[k] <= pc[k];
          sum_r[k] <= ns[k];
          a_r[k] <= pa[k];
          b_r[k] <= pb[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and randomized checks of adder_pipe against a queue-based arithmetic model
module tb_adder_pipe;
  localparam int W = 16;
  localparam int S = 4;
  logic clk = 0;
  logic reset_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic carry_in = 0;
  logic sub = 0;
  logic out_valid;
  logic out_ready = 1;
  logic [W-1:0] sum;
  logic carry_out;
  int n_checks = 0;
  int n_errors = 0;
  logic [W:0] exp_q [$];
  always #5 clk = ~clk;
  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .carry_in(carry_in),
`ifdef ADDER_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .carry_out(carry_out)
  );
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [W:0] model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
    logic [W:0] yy;
    yy = s ? (W+1)'((1 << W) - 1 - int'(y)) : {1'b0, y};
    return {1'b0, x} + yy + (W+1)'(ci);
  endfunction
  always @(negedge clk) begin
    if (!reset_n) exp_q.delete();
    else begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          check("result", {carry_out, sum}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, carry_in, sub));
    end
  end
  task automatic send_one(string tag, logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s,
                          logic [W-1:0] es, logic ec);
    int n;
    @(posedge clk); #1;
    a = x; b = y; carry_in = ci; sub = s; in_valid = 1; out_ready = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, S);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, carry_out, ec);
  endtask
  task automatic stream();
    int i, got;
    i = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 6 && c <= 10);
      in_valid = i < 8;
      a = W'(i * 'h1111); b = 'h0F0F; carry_in = 0; sub = 0;
      @(negedge clk);
      if (c >= 6 && c <= 10) check("bp_in_ready", in_ready, 0);
      if (c >= 11 && got < 8) check("bp_thru", out_valid, 1);
      if (in_valid && in_ready) i++;
      if (out_valid && out_ready) got++;
    end
    check("bp_count", got, 8);
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
  endtask
  initial begin
    int seen, n;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
    end
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sum", {carry_out, sum}, 0);
    send_one("basic", 'h0001, 'h0002, 0, 0, 'h0003, 0);
    send_one("ripple1", 'hFFFF, 'h0001, 0, 0, 'h0000, 1);
    send_one("ripple2", 'hFFFF, 'h0000, 1, 0, 'h0000, 1);
    stream();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1; a = W'($urandom); b = W'($urandom); carry_in = 0; sub = 0; out_ready = 1;
    end
    @(posedge clk); #1;
    in_valid = 0;
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_discard", seen, 0);
    send_one("after_rst", 'h1234, 'h1111, 0, 0, 'h2345, 0);
`ifdef ADDER_PIPE_SUB_EN
    send_one("sub1", 'h0005, 'h0007, 1, 1, 'hFFFE, 0);
    send_one("sub2", 'h0007, 'h0005, 1, 1, 'h0002, 1);
`endif
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a = W'($urandom);
      b = W'($urandom);
      carry_in = 1'($urandom_range(0, 1));
`ifdef ADDER_PIPE_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 0;
`endif
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
